dma_ctrl_regs: RTL and testbench

CPU-facing register front-end that sits directly upstream of the BrainForge8 DMA engine and drives its start/parameter inputs. Holds shadow parameter registers, a one-deep pending-descriptor slot, and a launch FSM that issues a one-cycle start only when the engine is idle. It collects the engine's DONE/FAIL/ERR pulses into sticky status flags and raises a level interrupt to the CPU.

---
 rtl/dma_ctrl_regs_pkg.sv | 55 +++++
 rtl/dma_desc_slot.sv | 50 +++++
 rtl/dma_ctrl_regs.sv | 187 ++++++++++++++++++
 tb/tb_dma_ctrl_regs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ctrl_regs_pkg.sv
// Shared register map, bit positions, FSM encodings and descriptor type
// for the DMA control register front-end.
package dma_ctrl_regs_pkg;

  // Register indices
  localparam logic [2:0] REG_SRC_LO = 3'd0;
  localparam logic [2:0] REG_SRC_HI = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_LEN    = 3'd4;
  localparam logic [2:0] REG_INC    = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  // CTRL bits: GO is a strobe, IE occupies bits 4:1
  localparam int CTRL_GO     = 0;
  localparam int CTRL_IE_LSB = 1;
  localparam int CTRL_IE_MSB = 4;

  // STATUS bits
  localparam int ST_BUSY = 0;
  localparam int ST_PEND = 1;
  localparam int ST_DONE = 2;
  localparam int ST_FAIL = 3;
  localparam int ST_ERR  = 4;
  localparam int ST_OVF  = 5;

  // Sticky flag vector order {OVF, ERR, FAIL, DONE}; matches IE order
  localparam int FLG_DONE = 0;
  localparam int FLG_FAIL = 1;
  localparam int FLG_ERR  = 2;
  localparam int FLG_OVF  = 3;

  // Launch FSM encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    logic [7:0]  inc;
  } dma_desc_t;

  localparam int DESC_W = 48;

  // STATUS byte assembled from its fields
  function automatic logic [7:0] status_byte(input logic [3:0] flags,
                                             input logic pend,
                                             input logic busy_fsm);
    return {2'b00, flags, pend, busy_fsm};
  endfunction

endpackage

// File: rtl/dma_desc_slot.sv
// One-deep pending descriptor slot. A push into a full slot is dropped and
// reported as overflow, unless the slot is being popped in the same cycle,
// in which case the pop frees it first and the push lands.
import dma_ctrl_regs_pkg::*;

module dma_desc_slot (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DESC_W-1:0] push_desc,
  input  logic              pop,
  output logic              full,
  output logic [DESC_W-1:0] desc,
  output logic              ovf
);

  logic              full_q, full_d;
  logic [DESC_W-1:0] desc_q, desc_d;

  // Next-state for slot occupancy and contents; pop is ordered before push
  always_comb begin
    full_d = full_q;
    desc_d = desc_q;
    ovf    = 1'b0;
    if (pop) full_d = 1'b0;
    if (push) begin
      if (full_q && !pop) begin
        ovf = 1'b1;
      end else begin
        full_d = 1'b1;
        desc_d = push_desc;
      end
    end
  end

  // Slot storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      desc_q <= '0;
    end else begin
      full_q <= full_d;
      desc_q <= desc_d;
    end
  end

  assign full = full_q;
  assign desc = desc_q;

endmodule

// File: rtl/dma_ctrl_regs.sv
// CPU register front-end for the DMA engine: shadow parameter registers,
// a pending-descriptor slot, a launch FSM issuing a one-cycle start when the
// engine is idle, sticky completion flags and a level interrupt.
import dma_ctrl_regs_pkg::*;

module dma_ctrl_regs #(
  parameter logic [3:0] ACK_MAX = 4'd8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [2:0]  ADDR,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        DMA_START,
  output logic [15:0] DMA_SRC,
  output logic [15:0] DMA_DST,
  output logic [7:0]  DMA_LEN,
  output logic [7:0]  DMA_INC,
  input  logic        DMA_BUSY,
  input  logic        DMA_DONE,
  input  logic        DMA_FAIL,
  input  logic        DMA_ERR,
  output logic        IRQ
);

  logic wr_en, rd_en, go;
  assign wr_en = CS & WE;
  assign rd_en = CS & ~WE;
  assign go    = wr_en && (ADDR == REG_CTRL) && DIN[CTRL_GO];

  // Shadow registers and interrupt enables
  logic [15:0] sh_src_q, sh_src_d, sh_dst_q, sh_dst_d;
  logic [7:0]  sh_len_q, sh_len_d, sh_inc_q, sh_inc_d;
  logic [3:0]  ie_q, ie_d;

  // Launch FSM, active descriptor, flags, read data
  logic [1:0]  state_q, state_d;
  logic [3:0]  ack_cnt_q, ack_cnt_d;
  logic        start_q, start_d;
  dma_desc_t   act_q, act_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  dout_q, dout_d;

  // Slot interface
  logic              slot_pop, slot_full, slot_ovf;
  logic [DESC_W-1:0] slot_desc;
  dma_desc_t         push_desc;
  logic              ack_timeout;
  logic [7:0]        rdata;
  logic [3:0]        flag_set, flag_clr;

  assign push_desc = '{src: sh_src_q, dst: sh_dst_q, len: sh_len_q, inc: sh_inc_q};

  dma_desc_slot u_slot (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (go),
    .push_desc (push_desc),
    .pop       (slot_pop),
    .full      (slot_full),
    .desc      (slot_desc),
    .ovf       (slot_ovf)
  );

  // CPU writes to shadow registers and interrupt enables
  always_comb begin
    sh_src_d = sh_src_q;
    sh_dst_d = sh_dst_q;
    sh_len_d = sh_len_q;
    sh_inc_d = sh_inc_q;
    ie_d     = ie_q;
    if (wr_en) begin
      case (ADDR)
        REG_SRC_LO: sh_src_d[7:0]  = DIN;
        REG_SRC_HI: sh_src_d[15:8] = DIN;
        REG_DST_LO: sh_dst_d[7:0]  = DIN;
        REG_DST_HI: sh_dst_d[15:8] = DIN;
        REG_LEN:    sh_len_d       = DIN;
        REG_INC:    sh_inc_d       = DIN;
        REG_CTRL:   ie_d           = DIN[CTRL_IE_MSB:CTRL_IE_LSB];
        default:    ;
      endcase
    end
  end

  // Launch FSM: start only from idle with a pending descriptor and a quiet
  // engine; give up waiting for BUSY after ACK_MAX cycles in S_ACK
  always_comb begin
    state_d     = state_q;
    ack_cnt_d   = ack_cnt_q;
    start_d     = 1'b0;
    act_d       = act_q;
    slot_pop    = 1'b0;
    ack_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (slot_full && !DMA_BUSY) begin
          slot_pop  = 1'b1;
          act_d     = dma_desc_t'(slot_desc);
          start_d   = 1'b1;
          ack_cnt_d = 4'd0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (DMA_BUSY) begin
          state_d = S_RUN;
        end else if (ack_cnt_q == ACK_MAX - 4'd1) begin
          ack_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        if (!DMA_BUSY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins
  always_comb begin
    flag_set           = 4'd0;
    flag_set[FLG_DONE] = DMA_DONE;
    flag_set[FLG_FAIL] = DMA_FAIL;
    flag_set[FLG_ERR]  = DMA_ERR | ack_timeout;
    flag_set[FLG_OVF]  = slot_ovf;
    flag_clr = (wr_en && ADDR == REG_STATUS) ? DIN[ST_OVF:ST_DONE] : 4'd0;
    flags_d  = flag_set | (flags_q & ~flag_clr);
  end

  // Read mux; DOUT only changes on a read
  always_comb begin
    case (ADDR)
      REG_SRC_LO: rdata = sh_src_q[7:0];
      REG_SRC_HI: rdata = sh_src_q[15:8];
      REG_DST_LO: rdata = sh_dst_q[7:0];
      REG_DST_HI: rdata = sh_dst_q[15:8];
      REG_LEN:    rdata = sh_len_q;
      REG_INC:    rdata = sh_inc_q;
      REG_CTRL:   rdata = {3'b000, ie_q, 1'b0};
      default:    rdata = status_byte(flags_q, slot_full, state_q != S_IDLE);
    endcase
    dout_d = rd_en ? rdata : dout_q;
  end

  // State registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_src_q  <= '0;
      sh_dst_q  <= '0;
      sh_len_q  <= '0;
      sh_inc_q  <= '0;
      ie_q      <= '0;
      state_q   <= S_IDLE;
      ack_cnt_q <= '0;
      start_q   <= 1'b0;
      act_q     <= '0;
      flags_q   <= '0;
      dout_q    <= '0;
    end else begin
      sh_src_q  <= sh_src_d;
      sh_dst_q  <= sh_dst_d;
      sh_len_q  <= sh_len_d;
      sh_inc_q  <= sh_inc_d;
      ie_q      <= ie_d;
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      start_q   <= start_d;
      act_q     <= act_d;
      flags_q   <= flags_d;
      dout_q    <= dout_d;
    end
  end

  assign DOUT      = dout_q;
  assign DMA_START = start_q;
  assign DMA_SRC   = act_q.src;
  assign DMA_DST   = act_q.dst;
  assign DMA_LEN   = act_q.len;
  assign DMA_INC   = act_q.inc;
  assign IRQ       = |(flags_q & ie_q);

endmodule

// File: tb/tb_dma_ctrl_regs.sv
// Bench for dma_ctrl_regs: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model of the register block.
module tb_dma_ctrl_regs;

  localparam int ACK_MAX = 8;

  logic        CLK = 1'b0, RST;
  logic        CS, WE, DMA_BUSY, DMA_DONE, DMA_FAIL, DMA_ERR;
  logic [2:0]  ADDR;
  logic [7:0]  DIN, DOUT, DMA_LEN, DMA_INC;
  logic [15:0] DMA_SRC, DMA_DST;
  logic        DMA_START, IRQ;

  always #5 CLK = ~CLK;

  dma_ctrl_regs #(.ACK_MAX(4'd8)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .DIN(DIN),
    .DOUT(DOUT), .DMA_START(DMA_START), .DMA_SRC(DMA_SRC), .DMA_DST(DMA_DST),
    .DMA_LEN(DMA_LEN), .DMA_INC(DMA_INC), .DMA_BUSY(DMA_BUSY),
    .DMA_DONE(DMA_DONE), .DMA_FAIL(DMA_FAIL), .DMA_ERR(DMA_ERR), .IRQ(IRQ)
  );

  int n_chk = 0, n_pass = 0, dut_starts = 0;
  logic eng_busy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_sh[8];
  logic [3:0]  m_ie;
  bit          m_done, m_fail, m_err, m_ovf, m_start;
  logic [47:0] m_pend[$];
  logic [15:0] m_src, m_dst;
  logic [7:0]  m_len, m_inc, m_dout;
  int          m_phase;   // 0 waiting for work, 1 started awaiting busy, 2 engine running
  int          m_wait;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_sh[i] = 8'h00;
    m_ie = 4'h0; m_done = 0; m_fail = 0; m_err = 0; m_ovf = 0; m_start = 0;
    m_pend.delete();
    m_src = 0; m_dst = 0; m_len = 0; m_inc = 0; m_dout = 0;
    m_phase = 0; m_wait = 0;
  endtask

  function automatic logic [7:0] m_status();
    return {2'b00, m_ovf, m_err, m_fail, m_done, m_pend.size() != 0, m_phase != 0};
  endfunction

  function automatic logic m_irq();
    return |({m_ovf, m_err, m_fail, m_done} & m_ie);
  endfunction

  task automatic m_step(input logic cs, we, input logic [2:0] a, input logic [7:0] d,
                        input logic busy, dn, fl, er);
    logic [7:0] rdata;
    bit launch, ack_fail, ovf_set;
    if (a < 3'd6)       rdata = m_sh[a];
    else if (a == 3'd6) rdata = {3'b000, m_ie, 1'b0};
    else                rdata = m_status();
    ack_fail = 0; ovf_set = 0;
    launch = (m_phase == 0) && (m_pend.size() > 0) && !busy;
    m_start = launch;
    if (launch) begin
      {m_src, m_dst, m_len, m_inc} = m_pend.pop_front();
      m_phase = 1; m_wait = 0;
    end else if (m_phase == 1) begin
      if (busy) m_phase = 2;
      else begin
        m_wait++;
        if (m_wait == ACK_MAX) begin ack_fail = 1; m_phase = 0; end
      end
    end else if (m_phase == 2 && !busy) m_phase = 0;
    if (cs && we && a == 3'd6 && d[0]) begin
      if (m_pend.size() == 0) m_pend.push_back({m_sh[1], m_sh[0], m_sh[3], m_sh[2], m_sh[4], m_sh[5]});
      else ovf_set = 1;
    end
    if (cs && we) begin
      if (a < 3'd6) m_sh[a] = d;
      else if (a == 3'd6) m_ie = d[4:1];
      else begin
        if (d[2]) m_done = 0;
        if (d[3]) m_fail = 0;
        if (d[4]) m_err = 0;
        if (d[5]) m_ovf = 0;
      end
    end
    if (dn) m_done = 1;
    if (fl) m_fail = 1;
    if (er || ack_fail) m_err = 1;
    if (ovf_set) m_ovf = 1;
    if (cs && !we) m_dout = rdata;
  endtask

  // ---------------- cycle driver ----------------
  task automatic cyc(input logic cs, we, input logic [2:0] a, input logic [7:0] d,
                     input logic busy, dn, fl, er);
    CS = cs; WE = we; ADDR = a; DIN = d;
    DMA_BUSY = busy; DMA_DONE = dn; DMA_FAIL = fl; DMA_ERR = er;
    m_step(cs, we, a, d, busy, dn, fl, er);
    @(posedge CLK); #1;
    if (DMA_START) dut_starts++;
    chk("dout", 64'(DOUT), 64'(m_dout));
    chk("start", 64'(DMA_START), 64'(m_start));
    chk("desc", 64'({DMA_SRC, DMA_DST, DMA_LEN, DMA_INC}), 64'({m_src, m_dst, m_len, m_inc}));
    chk("irq", 64'(IRQ), 64'(m_irq()));
    @(negedge CLK);
  endtask

  task automatic tick();
    cyc(1'b0, 1'b0, 3'd0, 8'h00, eng_busy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b1, a, d, eng_busy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    cyc(1'b1, 1'b0, a, 8'h00, eng_busy, 1'b0, 1'b0, 1'b0);
    chk(tag, 64'(DOUT), 64'(exp));
  endtask

  task automatic set_desc(input logic [15:0] s, input logic [15:0] t,
                          input logic [7:0] l, input logic [7:0] i);
    wr(3'd0, s[7:0]); wr(3'd1, s[15:8]); wr(3'd2, t[7:0]); wr(3'd3, t[15:8]);
    wr(3'd4, l); wr(3'd5, i);
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (DMA_START) seen = 1;
    end
    chk("start_seen", 64'(seen), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({DOUT, DMA_START, DMA_SRC, DMA_DST, DMA_LEN, DMA_INC, IRQ}), 64'd0);
  endtask

  initial begin
    RST = 1'b0; CS = 0; WE = 0; ADDR = 0; DIN = 0;
    DMA_BUSY = 0; DMA_DONE = 0; DMA_FAIL = 0; DMA_ERR = 0;
    m_reset();
    @(negedge CLK); @(negedge CLK);
    chk_all_zero("reset_outs");
    RST = 1'b1;
    @(negedge CLK);
    rd_chk("reset_status", 3'd7, 8'h00);

    // Basic launch: start is a single pulse one edge after GO is captured
    set_desc(16'h1234, 16'h8000, 8'd3, 8'd1);
    wr(3'd6, 8'h03);
    chk("go_no_start_yet", 64'(DMA_START), 64'd0);
    tick();
    chk("go_start", 64'(DMA_START), 64'd1);
    chk("go_desc", 64'({DMA_SRC, DMA_DST, DMA_LEN, DMA_INC}), 64'h1234_8000_03_01);
    eng_busy = 1'b1;
    tick();
    chk("start_one_cycle", 64'(DMA_START), 64'd0);
    rd_chk("status_running", 3'd7, 8'h01);
    repeat (8) tick();
    eng_busy = 1'b0;
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    rd_chk("status_done", 3'd7, 8'h04);
    chk("irq_done", 64'(IRQ), 64'd1);
    wr(3'd7, 8'h04);
    chk("irq_cleared", 64'(IRQ), 64'd0);

    // Overflow: B queued while running, C rejected
    set_desc(16'hA0A0, 16'h0A0A, 8'd5, 8'd2);
    wr(3'd6, 8'h03);
    wait_start();
    eng_busy = 1'b1;
    tick(); tick();
    set_desc(16'hB0B1, 16'hB2B3, 8'd0, 8'd4);
    wr(3'd6, 8'h03);
    set_desc(16'hC0C1, 16'hC2C3, 8'd7, 8'd7);
    wr(3'd6, 8'h03);
    rd_chk("status_ovf", 3'd7, 8'h23);
    eng_busy = 1'b0;
    wait_start();
    chk("b_launched", 64'({DMA_SRC, DMA_DST, DMA_LEN, DMA_INC}), 64'hB0B1_B2B3_00_04);
    eng_busy = 1'b1;
    repeat (3) tick();
    eng_busy = 1'b0;
    dut_starts = 0;
    repeat (20) tick();
    chk("c_never_launched", 64'(dut_starts), 64'd0);
    chk("b_stable", 64'(DMA_SRC), 64'hB0B1);
    wr(3'd7, 8'h20);

    // Ack timeout: BUSY never rises
    wr(3'd6, 8'h01);
    wait_start();
    repeat (7) tick();
    rd_chk("ack_wait_7", 3'd7, 8'h01);
    rd_chk("ack_timeout", 3'd7, 8'h10);
    wr(3'd6, 8'h08);
    chk("irq_err", 64'(IRQ), 64'd1);
    wr(3'd7, 8'h10);
    rd_chk("ctrl_read", 3'd6, 8'h08);

    // Set beats clear
    cyc(1'b1, 1'b1, 3'd7, 8'h08, eng_busy, 1'b0, 1'b1, 1'b0);
    rd_chk("fail_set_wins", 3'd7, 8'h08);

    // Reset while the engine runs
    set_desc(16'h5555, 16'hAAAA, 8'd9, 8'd3);
    wr(3'd6, 8'h1F);
    wait_start();
    eng_busy = 1'b1;
    tick(); tick();
    chk("irq_before_rst", 64'(IRQ), 64'd1);
    RST = 1'b0;
    #1;
    chk_all_zero("midrun_reset_outs");
    m_reset();
    eng_busy = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    rd_chk("post_rst_src_lo", 3'd0, 8'h00);
    rd_chk("post_rst_status", 3'd7, 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic cs, we, dn, fl, er;
      logic [2:0] a;
      logic [7:0] d;
      if ($urandom_range(0, 5) == 0) eng_busy = ~eng_busy;
      cs = ($urandom_range(0, 1) == 1);
      we = ($urandom_range(0, 1) == 1);
      a  = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      dn = ($urandom_range(0, 15) == 0);
      fl = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 15) == 0);
      cyc(cs, we, a, d, eng_busy, dn, fl, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
